// File: rtl/bg_pixel_fetcher_pkg.sv
// Shared PPU types and VRAM region bases.
// Used by the BG fetcher, its address helper and its bus interface.
package gameman_ppu_pkg;

   localparam logic [12:0] VRAM_MAP0     = 13'h1800;
   localparam logic [12:0] VRAM_MAP1     = 13'h1C00;
   localparam logic [12:0] VRAM_TILE8000 = 13'h0000;
   localparam logic [12:0] VRAM_TILE8800 = 13'h1000;

   localparam logic [1:0] SRC_BG = 2'b00;

   typedef struct packed {
      logic [1:0] src;
      logic [1:0] pal;
      logic [1:0] color;
   } pixel_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH_MAP,
      ST_CAP_MAP,
      ST_FETCH_LO,
      ST_CAP_LO,
      ST_FETCH_HI,
      ST_CAP_HI,
      ST_WAIT_SPACE,
      ST_PUSH
   } fetch_state_t;

endpackage

// File: rtl/bg_pixel_fetcher_if.sv
// VRAM read port and pixel FIFO push port of the BG fetcher.
// master = fetcher side, slave = VRAM/FIFO side.
interface bg_pixel_fetcher_if;
   import gameman_ppu_pkg::*;

   logic        vram_rd_out;
   logic [12:0] vram_addr_out;
   logic [7:0]  vram_data_in;
   logic [4:0]  fifo_count_in;
   logic        wr_en_out;
   pixel_t      pixel_out;

   modport master (
      output vram_rd_out, vram_addr_out,
      output wr_en_out, pixel_out,
      input  vram_data_in, fifo_count_in
   );

   modport slave (
      input  vram_rd_out, vram_addr_out,
      input  wr_en_out, pixel_out,
      output vram_data_in, fifo_count_in
   );

endinterface

// File: rtl/bg_pixel_fetcher_tile_addr.sv
// Combinational BG map and tile-row addresses for one tile slot.
// All 8-bit sums wrap mod 256; 13-bit addresses wrap too.
module ppu_tile_addr
   import gameman_ppu_pkg::*;
(
   input  logic [7:0]  ly_i,
   input  logic [7:0]  scx_i,
   input  logic [7:0]  scy_i,
   input  logic        map_sel_i,
   input  logic        data_sel_i,
   input  logic [4:0]  tile_idx_i,
   input  logic [7:0]  id_i,
   output logic [12:0] map_addr_o,
   output logic [12:0] lo_addr_o,
   output logic [12:0] hi_addr_o
);

   logic [7:0]  line_y;
   logic [2:0]  row;
   logic [4:0]  ty;
   logic [4:0]  tx;
   logic [12:0] tile_base;

   // Tile coordinates in the 32x32 map, then the row bytes of the tile.
   always_comb begin
      line_y     = ly_i + scy_i;
      row        = line_y[2:0];
      ty         = line_y[7:3];
      tx         = scx_i[7:3] + tile_idx_i;
      map_addr_o = (map_sel_i ? VRAM_MAP1 : VRAM_MAP0)
                 + {3'b000, ty, tx};
      if (data_sel_i) begin
         tile_base = VRAM_TILE8000 + {1'b0, id_i, 4'b0000};
      end else begin
         tile_base = VRAM_TILE8800 + {id_i[7], id_i, 4'b0000};
      end
      lo_addr_o = tile_base + {9'b0, row, 1'b0};
      hi_addr_o = lo_addr_o + 13'd1;
   end

endmodule

// File: rtl/bg_pixel_fetcher.sv
// BG tile fetcher: reads map/lo/hi per tile, pushes 8 pixels per tile.
// A start pulse at any time restarts the line from tile 0.
module bg_pixel_fetcher
   import gameman_ppu_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int NUM_TILES  = 21
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       start_in,
   input  logic [7:0]                 ly_in,
   input  logic [7:0]                 scx_in,
   input  logic [7:0]                 scy_in,
   input  logic                       bg_map_sel_in,
   input  logic                       tile_data_sel_in,
   bg_pixel_fetcher_if.master         bus,
   output logic                       busy_out,
   output logic                       done_out
);

   localparam logic [4:0] SPACE_MAX = 5'(FIFO_DEPTH - 8);
   localparam logic [4:0] LAST_TILE = 5'(NUM_TILES - 1);

   fetch_state_t state_q, state_d;
   logic [7:0]   ly_q, ly_d, scx_q, scx_d, scy_q, scy_d;
   logic         map_sel_q, map_sel_d, data_sel_q, data_sel_d;
   logic [4:0]   tile_q, tile_d;
   logic [2:0]   pix_q, pix_d;
   logic [7:0]   id_q, id_d, lo_q, lo_d, hi_q, hi_d;
   logic [12:0]  addr_q, addr_d;
   logic         done_q, done_d;

   logic [12:0]  map_addr, lo_addr, hi_addr;
   pixel_t       pix_out;

   // Addresses are computed from next-state values so they can be registered.
   ppu_tile_addr u_addr (
      .ly_i       (ly_d),
      .scx_i      (scx_d),
      .scy_i      (scy_d),
      .map_sel_i  (map_sel_d),
      .data_sel_i (data_sel_d),
      .tile_idx_i (tile_d),
      .id_i       (id_d),
      .map_addr_o (map_addr),
      .lo_addr_o  (lo_addr),
      .hi_addr_o  (hi_addr)
   );

   // State and datapath registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         ly_q       <= '0;
         scx_q      <= '0;
         scy_q      <= '0;
         map_sel_q  <= 1'b0;
         data_sel_q <= 1'b0;
         tile_q     <= '0;
         pix_q      <= '0;
         id_q       <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         addr_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ly_q       <= ly_d;
         scx_q      <= scx_d;
         scy_q      <= scy_d;
         map_sel_q  <= map_sel_d;
         data_sel_q <= data_sel_d;
         tile_q     <= tile_d;
         pix_q      <= pix_d;
         id_q       <= id_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
      end
   end

   // Next state; a start pulse overrides everything, including the last push.
   always_comb begin
      state_d    = state_q;
      ly_d       = ly_q;
      scx_d      = scx_q;
      scy_d      = scy_q;
      map_sel_d  = map_sel_q;
      data_sel_d = data_sel_q;
      tile_d     = tile_q;
      pix_d      = pix_q;
      id_d       = id_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      done_d     = 1'b0;
      if (start_in) begin
         ly_d       = ly_in;
         scx_d      = scx_in;
         scy_d      = scy_in;
         map_sel_d  = bg_map_sel_in;
         data_sel_d = tile_data_sel_in;
         tile_d     = '0;
         pix_d      = '0;
         state_d    = ST_FETCH_MAP;
      end else begin
         unique case (state_q)
            ST_IDLE:      state_d = ST_IDLE;
            ST_FETCH_MAP: state_d = ST_CAP_MAP;
            ST_CAP_MAP: begin
               id_d    = bus.vram_data_in;
               state_d = ST_FETCH_LO;
            end
            ST_FETCH_LO:  state_d = ST_CAP_LO;
            ST_CAP_LO: begin
               lo_d    = bus.vram_data_in;
               state_d = ST_FETCH_HI;
            end
            ST_FETCH_HI:  state_d = ST_CAP_HI;
            ST_CAP_HI: begin
               hi_d    = bus.vram_data_in;
               state_d = ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: begin
               if (bus.fifo_count_in <= SPACE_MAX) begin
                  pix_d   = '0;
                  state_d = ST_PUSH;
               end
            end
            ST_PUSH: begin
               lo_d  = {lo_q[6:0], 1'b0};
               hi_d  = {hi_q[6:0], 1'b0};
               pix_d = pix_q + 3'd1;
               if (pix_q == 3'd7) begin
                  if (tile_q == LAST_TILE) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     tile_d  = tile_q + 5'd1;
                     state_d = ST_FETCH_MAP;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Registered VRAM address for the upcoming fetch cycle.
   always_comb begin
      addr_d = '0;
      unique case (state_d)
         ST_FETCH_MAP: addr_d = map_addr;
         ST_FETCH_LO:  addr_d = lo_addr;
         ST_FETCH_HI:  addr_d = hi_addr;
         default:      addr_d = '0;
      endcase
   end

   // Pixel word: MSB of the shift registers is the current pixel.
   always_comb begin
      pix_out       = '0;
      pix_out.src   = SRC_BG;
      pix_out.pal   = 2'b00;
      if (state_q == ST_PUSH) begin
         pix_out.color = {hi_q[7], lo_q[7]};
      end
   end

   assign bus.vram_rd_out   = (state_q == ST_FETCH_MAP)
                            | (state_q == ST_FETCH_LO)
                            | (state_q == ST_FETCH_HI);
   assign bus.vram_addr_out = addr_q;
   assign bus.wr_en_out     = (state_q == ST_PUSH);
   assign bus.pixel_out     = pix_out;
   assign busy_out          = (state_q != ST_IDLE);
   assign done_out          = done_q;

endmodule
